// File: rtl/apb_master_ctrl.sv
// apb_master_ctrl: single-outstanding APB master turning local commands into
// SETUP/ACCESS transfers with a bounded wait for p_ready_i.
module apb_master_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        p_clk_i,
    input  logic        p_rst_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_we_i,
    input  logic [31:0] cmd_adr_i,
    input  logic [31:0] cmd_dat_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_dat_o,
    output logic        rsp_err_o,
    output logic        p_sel_o,
    output logic        p_enable_o,
    output logic        p_we_o,
    output logic [31:0] p_adr_o,
    output logic [31:0] p_dat_o,
    input  logic [31:0] p_dat_i,
    input  logic        p_ready_i
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        we_q, we_d, err_q, err_d;
    logic [31:0] adr_q, adr_d, dat_q, dat_d, rdat_q, rdat_d;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        rdat_d  = rdat_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (cmd_valid_i) begin
                state_d = SETUP;
                we_d    = cmd_we_i;
                adr_d   = cmd_adr_i;
                dat_d   = cmd_dat_i;
            end
            SETUP: begin
                state_d = ACCESS;
                cnt_d   = '0;
            end
            ACCESS: if (p_ready_i) begin
                // a ready in the final allowed cycle still completes normally
                state_d = RESP;
                err_d   = 1'b0;
                rdat_d  = we_q ? '0 : p_dat_i;
            end else if (cnt_q == TO_LAST) begin
                state_d = RESP;
                err_d   = 1'b1;
                rdat_d  = '0;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
            RESP: state_d = IDLE;
        endcase
    end
    always_ff @(posedge p_clk_i) begin
        if (p_rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            rdat_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            rdat_q  <= rdat_d;
            err_q   <= err_d;
        end
    end
    assign cmd_ready_o = state_q == IDLE;
    assign p_sel_o     = state_q == SETUP || state_q == ACCESS;
    assign p_enable_o  = state_q == ACCESS;
    assign rsp_valid_o = state_q == RESP;
    assign rsp_err_o   = state_q == RESP && err_q;
    assign rsp_dat_o   = rdat_q;
    assign p_we_o      = we_q;
    assign p_adr_o     = adr_q;
    assign p_dat_o     = dat_q;
endmodule

// File: tb/tb_apb_master_ctrl.sv
// tb_apb_master_ctrl: directed APB master bench with a transaction-level
// reference model compared on every cycle plus hand-computed latency checks.
module tb_apb_master_ctrl;
    localparam int TO = 8;
    logic        clk = 0, rst = 1;
    logic        cmd_valid_i = 0, cmd_we_i = 0, p_ready_i = 0;
    logic [31:0] cmd_adr_i = 0, cmd_dat_i = 0, p_dat_i = 0;
    logic        cmd_ready_o, rsp_valid_o, rsp_err_o, p_sel_o, p_enable_o, p_we_o;
    logic [31:0] rsp_dat_o, p_adr_o, p_dat_o;
    int checks = 0, failures = 0, cyc = 0;

    apb_master_ctrl #(.TIMEOUT(TO)) dut (
        .p_clk_i(clk), .p_rst_i(rst), .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_we_i(cmd_we_i), .cmd_adr_i(cmd_adr_i), .cmd_dat_i(cmd_dat_i),
        .rsp_valid_o(rsp_valid_o), .rsp_dat_o(rsp_dat_o), .rsp_err_o(rsp_err_o),
        .p_sel_o(p_sel_o), .p_enable_o(p_enable_o), .p_we_o(p_we_o), .p_adr_o(p_adr_o),
        .p_dat_o(p_dat_o), .p_dat_i(p_dat_i), .p_ready_i(p_ready_i)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Responder: asserts ready on the ready_at-th ACCESS cycle (0 = never).
    int ready_at = 0, acc_seen = 0;
    logic force_rdy = 0;
    logic [31:0] rd_data = 0;
    always @(negedge clk) begin
        acc_seen  = p_enable_o ? acc_seen + 1 : 0;
        p_ready_i = (p_enable_o && acc_seen == ready_at) || (!p_enable_o && force_rdy);
        p_dat_i   = p_ready_i ? rd_data : 32'hDEAD_BEEF;
    end

    // Transaction model: k counts cycles since acceptance, acc counts ACCESS cycles.
    int k = 0, acc = 0;
    logic m_resp = 0, m_err = 0, m_we = 0;
    logic [31:0] m_rdat = 0, m_adr = 0, m_dat = 0;
    always @(posedge clk) begin
        if (rst) begin
            k = 0; acc = 0; m_resp = 0; m_err = 0; m_rdat = 0; m_we = 0; m_adr = 0; m_dat = 0;
        end else if (m_resp) m_resp = 0;
        else if (k == 0) begin
            if (cmd_valid_i) begin
                k = 1; m_we = cmd_we_i; m_adr = cmd_adr_i; m_dat = cmd_dat_i;
            end
        end else if (k == 1) begin
            k = 2; acc = 1;
        end else if (p_ready_i) begin
            m_resp = 1; m_err = 0; m_rdat = m_we ? 0 : p_dat_i; k = 0;
        end else if (acc == TO) begin
            m_resp = 1; m_err = 1; m_rdat = 0; k = 0;
        end else acc++;
    end

    // Per-cycle comparison plus event recording for the literal checks.
    int acc_last = 0, en_cnt = 0, rsp_n = 0, rsp_cyc = 0;
    always @(negedge clk) begin
        if (cyc > 0) begin
            chk("cmd_ready", {31'd0, cmd_ready_o}, {31'd0, k == 0 && !m_resp});
            chk("p_sel", {31'd0, p_sel_o}, {31'd0, k >= 1});
            chk("p_enable", {31'd0, p_enable_o}, {31'd0, k >= 2});
            chk("rsp_valid", {31'd0, rsp_valid_o}, {31'd0, m_resp});
            chk("rsp_err", {31'd0, rsp_err_o}, {31'd0, m_resp && m_err});
            chk("rsp_dat", rsp_dat_o, m_rdat);
            chk("p_we", {31'd0, p_we_o}, {31'd0, m_we});
            chk("p_adr", p_adr_o, m_adr);
            chk("p_dat", p_dat_o, m_dat);
        end
        if (cmd_valid_i && cmd_ready_o) acc_last = cyc;
        if (p_enable_o) en_cnt++;
        if (rsp_valid_o) begin
            rsp_n++; rsp_cyc = cyc;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] dat);
        @(posedge clk); #1;
        cmd_we_i = we; cmd_adr_i = adr; cmd_dat_i = dat; cmd_valid_i = 1; en_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cmd_ready_o) break;
        end
        chk("accept_bound", {31'd0, cmd_ready_o}, 32'd1);
        @(posedge clk); #1;
        cmd_valid_i = 0;
    endtask

    task automatic wait_rsp();
        int n0 = rsp_n;
        logic ok = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (rsp_n != n0) begin
                ok = 1; break;
            end
        end
        chk("rsp_bound", {31'd0, ok}, 32'd1);
    endtask

    initial begin
        int a1, n0;
        step(3);
        rst = 0;
        step(1);
        chk("reset_ready", {31'd0, cmd_ready_o}, 32'd1);
        chk("reset_sel", {31'd0, p_sel_o}, 32'd0);
        chk("reset_rsp_dat", rsp_dat_o, 32'd0);
        // single-cycle write
        ready_at = 1;
        issue(1, 32'h0, 32'hA5);
        wait_rsp();
        chk("wr_latency", 32'(rsp_cyc - acc_last), 32'd3);
        chk("wr_err", {31'd0, rsp_err_o}, 32'd0);
        chk("wr_dat", rsp_dat_o, 32'd0);
        chk("wr_enable_cycles", 32'(en_cnt), 32'd1);
        @(negedge clk); #1;
        chk("wr_ready_again", {31'd0, cmd_ready_o}, 32'd1);
        chk("wr_ready_cycle", 32'(cyc - acc_last), 32'd4);
        // read with wait states
        ready_at = 4; rd_data = 32'h3C;
        issue(0, 32'h4, 32'h0);
        wait_rsp();
        chk("rd_latency", 32'(rsp_cyc - acc_last), 32'd6);
        chk("rd_dat", rsp_dat_o, 32'h3C);
        chk("rd_err", {31'd0, rsp_err_o}, 32'd0);
        chk("rd_enable_cycles", 32'(en_cnt), 32'd4);
        // timeout
        ready_at = 0;
        issue(0, 32'h8, 32'h0);
        wait_rsp();
        chk("to_latency", 32'(rsp_cyc - acc_last), 32'd10);
        chk("to_err", {31'd0, rsp_err_o}, 32'd1);
        chk("to_dat", rsp_dat_o, 32'd0);
        chk("to_enable_cycles", 32'(en_cnt), 32'd8);
        @(negedge clk); #1;
        chk("to_idle", {31'd0, cmd_ready_o}, 32'd1);
        // ready on the last allowed cycle wins over timeout
        ready_at = 8; rd_data = 32'h1234_5678;
        issue(0, 32'hC, 32'h0);
        wait_rsp();
        chk("edge_err", {31'd0, rsp_err_o}, 32'd0);
        chk("edge_dat", rsp_dat_o, 32'h1234_5678);
        chk("edge_enable_cycles", 32'(en_cnt), 32'd8);
        // back-to-back with cmd_valid held and data changing mid-transfer
        ready_at = 1;
        @(posedge clk); #1;
        cmd_we_i = 1; cmd_adr_i = 32'h8; cmd_dat_i = 32'h11; cmd_valid_i = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cmd_ready_o) break;
        end
        @(posedge clk); #1;
        a1 = acc_last;
        cmd_adr_i = 32'h10; cmd_dat_i = 32'h22;
        @(negedge clk); #1;
        chk("b2b_pdat_hold", p_dat_o, 32'h11);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            if (acc_last != a1) break;
        end
        chk("b2b_gap", 32'(acc_last - a1), 32'd4);
        @(posedge clk); #1;
        cmd_valid_i = 0;
        wait_rsp();
        chk("b2b_second_pdat", p_dat_o, 32'h22);
        // reset during ACCESS aborts silently
        ready_at = 0;
        issue(0, 32'h20, 32'h0);
        step(2);
        chk("abort_in_access", {31'd0, p_enable_o}, 32'd1);
        n0 = rsp_n;
        rst = 1;
        step(1);
        rst = 0;
        @(negedge clk); #1;
        chk("abort_sel", {31'd0, p_sel_o}, 32'd0);
        chk("abort_enable", {31'd0, p_enable_o}, 32'd0);
        step(15);
        chk("abort_no_rsp", 32'(rsp_n - n0), 32'd0);
        // stray ready pulse while idle
        force_rdy = 1; rd_data = 32'h55;
        step(3);
        force_rdy = 0;
        step(2);
        chk("stray_no_rsp", 32'(rsp_n - n0), 32'd0);
        chk("stray_rsp_dat", rsp_dat_o, 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/apb_master_ctrl.md
APB_MASTER_CTRL -- requirements
Module: apb_master_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: maximum ACCESS cycles without p_ready_i before error; legal range 1..65535.
REQ-002 SHALL have port p_clk_i  input  1  single clock; all logic on its rising edge.
REQ-003 SHALL have port p_rst_i  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port cmd_valid_i  input  1  command request from local user.
REQ-005 SHALL have port cmd_ready_o  output  1  command accepted when valid & ready.
REQ-006 SHALL have port cmd_we_i  input  1  1 = write, 0 = read.
REQ-007 SHALL have port cmd_adr_i  input  32  target APB address.
REQ-008 SHALL have port cmd_dat_i  input  32  write data.
REQ-009 SHALL have port rsp_valid_o  output  1  one-cycle response strobe.
REQ-010 SHALL have port rsp_dat_o  output  32  read data; 0 for writes and errors.
REQ-011 SHALL have port rsp_err_o  output  1  timeout flag; valid with rsp_valid_o.
REQ-012 SHALL have port p_sel_o  output  1  APB select.
REQ-013 SHALL have port p_enable_o  output  1  APB enable.
REQ-014 SHALL have port p_we_o  output  1  APB write.
REQ-015 SHALL have port p_adr_o  output  32  APB address.
REQ-016 SHALL have port p_dat_o  output  32  APB write data.
REQ-017 SHALL have port p_dat_i  input  32  APB read data.
REQ-018 SHALL have port p_ready_i  input  1  APB completion from responder.

Function
REQ-019 SHALL implement FSM states IDLE, SETUP, ACCESS, RESP.
REQ-020 SHALL drive cmd_ready_o = 1 in IDLE only; in other states commands are not accepted.
REQ-021 IDLE -> SETUP on cmd_valid_i & cmd_ready_o; cmd_we_i/adr/dat registered into p_we_o/p_adr_o/p_dat_o on that edge.
REQ-022 SETUP: p_sel_o = 1, p_enable_o = 0; unconditional -> ACCESS next cycle.
REQ-023 ACCESS: p_sel_o = 1, p_enable_o = 1; remains until p_ready_i sampled 1 or timeout.
REQ-024 p_we_o, p_adr_o, p_dat_o SHALL be stable from SETUP through last ACCESS cycle; outside a transfer they hold last values.
REQ-025 Timeout counter (16 bit) SHALL be 0 on ACCESS entry, increment each ACCESS cycle with p_ready_i = 0; when counter == TIMEOUT-1 and p_ready_i = 0, go to RESP with error.
REQ-026 p_ready_i = 1 in the same cycle as timeout SHALL complete normally (success wins).
REQ-027 On p_ready_i = 1 in ACCESS with p_we_o = 0, p_dat_i SHALL be captured into rsp_dat_o; for writes rsp_dat_o = 0.
REQ-028 RESP: p_sel_o = 0, p_enable_o = 0, rsp_valid_o = 1 for exactly one cycle; -> IDLE next cycle; no response backpressure.
REQ-029 rsp_err_o = 1 only in RESP after timeout, with rsp_dat_o = 0; otherwise 0.
REQ-030 rsp_dat_o SHALL hold its value until the next RESP.
REQ-031 p_ready_i and p_dat_i SHALL be ignored outside ACCESS.
REQ-032 Minimum latency: accept at cycle N, SETUP N+1, ACCESS N+2, rsp_valid_o at N+3 if p_ready_i = 1 at N+2, cmd_ready_o = 1 again at N+4.
REQ-033 p_sel_o SHALL never be 0 while p_enable_o = 1.

Reset
REQ-034 On p_rst_i = 1 at a clock edge: state IDLE; cmd_ready_o = 1 after reset release; all other outputs 0; timeout counter 0.
REQ-035 Reset mid-transfer SHALL abort the transfer with no rsp_valid_o pulse; p_sel_o/p_enable_o = 0 on the next edge.

Verification
REQ-036 Write adr 0x0, dat 0xA5, p_ready_i = 1 at first ACCESS -> SETUP/ACCESS one cycle each, rsp_valid_o at N+3, rsp_err_o = 0, rsp_dat_o = 0.
REQ-037 Read adr 0x4, responder asserts p_ready_i on 4th ACCESS cycle with p_dat_i = 0x0000_003C -> p_enable_o high 4 cycles, rsp_dat_o = 0x3C, rsp_err_o = 0.
REQ-038 TIMEOUT = 8, p_ready_i held 0 -> exactly 8 ACCESS cycles, rsp_valid_o with rsp_err_o = 1, rsp_dat_o = 0, then IDLE.
REQ-039 TIMEOUT = 8, p_ready_i = 1 on 8th ACCESS cycle -> success, rsp_err_o = 0.
REQ-040 cmd_valid_i held 1 with two back-to-back commands -> second accepted only at N+4; cmd_dat_i changes during first transfer do not alter p_dat_o.
REQ-041 p_rst_i = 1 during ACCESS -> no rsp_valid_o, p_sel_o = p_enable_o = 0 next cycle; p_ready_i pulse outside ACCESS -> no effect.
